// File: rtl/cache_control.sv
// cache_control: sequencing FSM for a 2-way, 16-set, 32-byte-line write-back
// cache datapath. It sits between the CPU memory port and physical memory,
// drives the datapath load/select strobes, and consumes tag_hit/valid/dirty.
// Handles hits, clean-miss allocate, and dirty-miss writeback then allocate.
// Optional performance counters are enabled with macro CACHE_PERF_CNT_EN.
module cache_control #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 tag_hit,
    input  logic                 valid,
    input  logic                 dirty,
    input  logic                 pmem_resp,
    output logic                 mem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic                 load_data,
    output logic                 load_valid,
    output logic                 load_dirty,
    output logic                 load_lru,
    output logic                 load_tag,
    output logic                 clear_dirty,
    output logic                 cache_in_sel,
    output logic                 pmem_addr_sel,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic w_req;
    logic w_hit;
    logic w_miss;

    // A simultaneous read+write is handled as a write, so mem_write alone
    // decides whether the hit merges CPU data.
    assign w_req  = mem_read | mem_write;
    assign w_hit  = w_req & tag_hit & valid;
    assign w_miss = w_req & ~w_hit;

    // State register; reset returns to IDLE from any state on the edge.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode; pmem requests are held until pmem_resp.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_miss) w_next = (valid & dirty) ? S_WRITEBACK : S_ALLOCATE;
            end
            S_WRITEBACK: begin
                if (pmem_resp) w_next = S_ALLOCATE;
            end
            S_ALLOCATE: begin
                if (pmem_resp) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode; everything is forced low while reset is high so a reset
    // mid-miss never strobes the arrays.
    always_comb begin
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        load_data     = 1'b0;
        load_valid    = 1'b0;
        load_dirty    = 1'b0;
        load_lru      = 1'b0;
        load_tag      = 1'b0;
        clear_dirty   = 1'b0;
        cache_in_sel  = 1'b0;
        pmem_addr_sel = 1'b0;
        if (!reset) begin
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        mem_resp = 1'b1;
                        load_lru = 1'b1;
                        if (mem_write) begin
                            load_data    = 1'b1;
                            cache_in_sel = 1'b1;
                            load_dirty   = 1'b1;
                        end
                    end
                end
                S_WRITEBACK: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                end
                S_ALLOCATE: begin
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        load_data   = 1'b1;
                        load_tag    = 1'b1;
                        load_valid  = 1'b1;
                        load_dirty  = 1'b1;
                        clear_dirty = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_PERF_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] r_hit_count;
    logic [CNT_WIDTH-1:0] r_miss_count;

    // Hit/miss counters, sampled only in IDLE; the refill-hit cycle after a
    // miss counts as a hit too. Both wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_hit)  r_hit_count  <= r_hit_count + CNT_ONE;
            if (w_miss) r_miss_count <= r_miss_count + CNT_ONE;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: doc/cache_control.md
Name: cache_control

Overview:
- Sequencing FSM for the 2-way, 16-set, 32-byte-line write-back cache datapath.
- Sits between the CPU memory port (mem_read/mem_write/mem_resp) and physical memory (pmem_read/pmem_write/pmem_resp).
- Drives every load/select strobe of the datapath and consumes its tag_hit/valid/dirty status.
- Handles hits, clean-miss allocate, and dirty-miss writeback followed by allocate.

Parameters:
- CNT_WIDTH, 16, width of the performance counters (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- mem_read  input  1  CPU read request, held until mem_resp
- mem_write  input  1  CPU write request, held until mem_resp
- tag_hit  input  1  datapath: addressed tag matches one way
- valid  input  1  datapath: valid bit of hit way (or LRU way on miss)
- dirty  input  1  datapath: dirty bit of LRU way
- pmem_resp  input  1  physical memory done, 1-cycle pulse
- mem_resp  output  1  CPU request complete, 1-cycle pulse
- pmem_read  output  1  physical memory line read request
- pmem_write  output  1  physical memory line write request
- load_data, load_valid, load_dirty, load_lru, load_tag  output  1 each  datapath array write strobes
- clear_dirty  output  1  with load_dirty: write 0 instead of 1
- cache_in_sel  output  1  0 = line from pmem_rdata, 1 = merged CPU write data
- pmem_addr_sel  output  1  0 = requested line address, 1 = evicted line address (LRU tag)
- hit_count, miss_count  output  CNT_WIDTH  performance counters

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- States: IDLE, WRITEBACK, ALLOCATE. Reset state is IDLE.
- Output style: all outputs are combinational decodes of state and inputs.
- While reset=1, every output is 0 and counters clear at the edge.
- Default: every output 0 unless stated below.

IDLE with req = mem_read|mem_write:
- req=0: hold IDLE.
- req & tag_hit & valid (hit): mem_resp=1 and load_lru=1 in the same cycle, so hit latency is 0 wait cycles.
- Write hit additionally: load_data=1, cache_in_sel=1, load_dirty=1, clear_dirty=0. State stays IDLE.
- Miss with valid & dirty: next state WRITEBACK.
- Miss otherwise: next state ALLOCATE.
- mem_read & mem_write together is illegal; the controller treats it as a write.

WRITEBACK:
- Drives pmem_write=1 and pmem_addr_sel=1 every cycle.
- On pmem_resp: next state ALLOCATE.

ALLOCATE:
- Drives pmem_read=1 and pmem_addr_sel=0.
- On pmem_resp, in that cycle: load_data=1, cache_in_sel=0, load_tag=1, load_valid=1, load_dirty=1, clear_dirty=1. Next state IDLE.
- The request then hits in IDLE on the following cycle. A write merges its data in that hit cycle.

Timing and boundary rules:
- Clean-miss latency: allocate cycles + 1.
- Dirty-miss latency: writeback cycles + allocate cycles + 1.
- pmem requests stay asserted until pmem_resp; no request is dropped early.
- If the CPU deasserts its request mid-miss, the miss transaction still completes; IDLE then idles with no mem_resp.
- mem_resp is never asserted outside IDLE.
- pmem_read and pmem_write are never asserted together.
- Reset asserted mid-WRITEBACK or mid-ALLOCATE: return to IDLE on that edge with no array strobes.
- A pmem_resp arriving in IDLE is ignored.

Optional Feature:
- Macro: CACHE_PERF_CNT_EN.
- Defined:
  - hit_count increments on each IDLE cycle with req & tag_hit & valid.
  - miss_count increments on each IDLE cycle that transitions to WRITEBACK or ALLOCATE. Each miss counts once; its refill-hit cycle also counts as a hit.
  - Both wrap modulo 2^CNT_WIDTH and clear on reset.
- Not defined: no counter registers; hit_count and miss_count are tied to 0.

Test Plan:
- Reset, then mem_read=1 with tag_hit=1, valid=1 -> mem_resp=1 and load_lru=1 in the same cycle; load_data=0; state stays IDLE.
- mem_write=1 hit -> same cycle load_data=1, cache_in_sel=1, load_dirty=1, clear_dirty=0, mem_resp=1.
- mem_read miss with valid=0, pmem_resp after 3 cycles -> pmem_read=1 for 4 cycles with pmem_addr_sel=0; in the resp cycle load_tag, load_valid, load_data and clear_dirty are 1; mem_resp 1 cycle later.
- mem_write miss with valid=1, dirty=1:
  - pmem_write=1 with pmem_addr_sel=1 until pmem_resp, then pmem_read=1 until pmem_resp.
  - Then a write hit: load_data=1, cache_in_sel=1, load_dirty=1.
  - pmem_read and pmem_write are never both 1.
- reset=1 asserted on the 2nd cycle of WRITEBACK -> all outputs 0 that cycle; IDLE next cycle; a later pmem_resp produces no strobes.
- With CACHE_PERF_CNT_EN and CNT_WIDTH=4: 3 hits and 1 clean miss -> hit_count=4 (including the refill hit), miss_count=1. 16 more hits -> hit_count wraps to 4.
